// File: rtl/vec_reg_unloader_if.sv
`default_nettype none
// ============================================================================
// Module      : vec_reg_unloader_if
// Description : Command, register-file read and lane-stream signals of the
//               vector register unloader.
// Revision    : 1.0
// ============================================================================
interface vec_reg_unloader_if #(
    parameter int LEN        = 16,
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 5
);
    localparam int LW = $clog2(LEN);

    logic                  cmd_valid;
    logic                  cmd_ready;
    logic [ADDR_WIDTH-1:0] cmd_addr;
    logic [ADDR_WIDTH-1:0] cmd_nregs_m1;
    logic [LW-1:0]         cmd_nlanes_m1;
    logic [ADDR_WIDTH-1:0] rf_addr;
    logic [DATA_WIDTH-1:0] rf_data [LEN];
    logic                  out_valid;
    logic                  out_ready;
    logic [DATA_WIDTH-1:0] out_data;
    logic                  out_last;
    logic                  busy;

    // Environment side: issues commands, serves register reads, sinks lanes.
    modport master (
        output cmd_valid, cmd_addr, cmd_nregs_m1, cmd_nlanes_m1, rf_data, out_ready,
        input  cmd_ready, rf_addr, out_valid, out_data, out_last, busy
    );

    // Unloader side.
    modport slave (
        input  cmd_valid, cmd_addr, cmd_nregs_m1, cmd_nlanes_m1, rf_data, out_ready,
        output cmd_ready, rf_addr, out_valid, out_data, out_last, busy
    );
endinterface
`default_nettype wire

// File: rtl/vec_reg_unloader.sv
`default_nettype none
// ============================================================================
// Module      : vec_reg_unloader
// Description : Streams selected lanes of consecutive vector registers, one
//               lane word per handshake, from a per-register snapshot.
// Revision    : 1.0
// ============================================================================
module vec_reg_unloader #(
    parameter int LEN        = 16,
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 5
) (
    input  wire logic         clk,
    input  wire logic         rst_n,
    vec_reg_unloader_if.slave bus
);
    localparam int LW = $clog2(LEN);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        FETCH  = 2'd1,
        STREAM = 2'd2
    } state_t;

    state_t                state_q, state_d;
    logic [ADDR_WIDTH-1:0] rf_addr_q, rf_addr_d;
    logic [ADDR_WIDTH-1:0] reg_cnt_q, reg_cnt_d;
    logic [LW-1:0]         nlanes_q, nlanes_d;
    logic [LW-1:0]         lane_q, lane_d;
    logic [DATA_WIDTH-1:0] snap_q [LEN];

    logic w_cmd_ready;
    logic w_accept;
    logic w_stream;
    logic w_hs;
    logic w_lane_end;
    logic w_last;

    // Outputs are qualified by rst_n so nothing is offered during a reset cycle.
    assign w_cmd_ready = rst_n && (state_q == IDLE);
    assign w_accept    = bus.cmd_valid && w_cmd_ready;
    assign w_stream    = rst_n && (state_q == STREAM);
    assign w_hs        = w_stream && bus.out_ready;
    assign w_lane_end  = (lane_q == nlanes_q);
    assign w_last      = w_stream && w_lane_end && (reg_cnt_q == '0);

    assign bus.cmd_ready = w_cmd_ready;
    assign bus.rf_addr   = rf_addr_q;
    assign bus.out_valid = w_stream;
    assign bus.out_data  = w_stream ? snap_q[lane_q] : '0;
    assign bus.out_last  = w_last;
    assign bus.busy      = rst_n && (state_q != IDLE);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            rf_addr_q <= '0;
            reg_cnt_q <= '0;
            nlanes_q  <= '0;
            lane_q    <= '0;
        end else begin
            state_q   <= state_d;
            rf_addr_q <= rf_addr_d;
            reg_cnt_q <= reg_cnt_d;
            nlanes_q  <= nlanes_d;
            lane_q    <= lane_d;
        end
    end

    // Snapshot taken in FETCH includes any write the register file forwards that cycle.
    always_ff @(posedge clk) begin
        if (rst_n && (state_q == FETCH)) begin
            snap_q <= bus.rf_data;
        end
    end

    always_comb begin
        state_d   = state_q;
        rf_addr_d = rf_addr_q;
        reg_cnt_d = reg_cnt_q;
        nlanes_d  = nlanes_q;
        lane_d    = lane_q;
        unique case (state_q)
            IDLE: begin
                if (w_accept) begin
                    rf_addr_d = bus.cmd_addr;
                    reg_cnt_d = bus.cmd_nregs_m1;
                    nlanes_d  = bus.cmd_nlanes_m1;
                    state_d   = FETCH;
                end
            end
            FETCH: begin
                lane_d  = '0;
                state_d = STREAM;
            end
            STREAM: begin
                if (w_hs) begin
                    if (!w_lane_end) begin
                        lane_d = lane_q + 1'b1;
                    end else if (reg_cnt_q != '0) begin
                        rf_addr_d = rf_addr_q + 1'b1;
                        reg_cnt_d = reg_cnt_q - 1'b1;
                        state_d   = FETCH;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end
endmodule
`default_nettype wire

// File: doc/vec_reg_unloader.md
VEC_REG_UNLOADER -- requirements
Module: vec_reg_unloader

Interface
REQ-001 SHALL have parameter LEN, default 16, meaning lanes per vector register.
REQ-002 SHALL have parameter DATA_WIDTH, default 32, meaning bits per lane.
REQ-003 SHALL have parameter ADDR_WIDTH, default 5, meaning register-file address width; the register file has 2^ADDR_WIDTH entries.
REQ-004 SHALL derive LW = $clog2(LEN), the lane-index width (4 at default).
REQ-005 SHALL have port clk, input, 1, meaning clock; all state updates on its rising edge.
REQ-006 SHALL have port rst_n, input, 1, meaning reset, synchronous, active-low.
REQ-007 SHALL have port cmd_valid, input, 1, meaning an unload command is offered.
REQ-008 SHALL have port cmd_ready, output, 1, meaning the block accepts a command this cycle.
REQ-009 SHALL have port cmd_addr, input, ADDR_WIDTH, meaning the first register to unload.
REQ-010 SHALL have port cmd_nregs_m1, input, ADDR_WIDTH, meaning the register count minus 1.
REQ-011 SHALL have port cmd_nlanes_m1, input, LW, meaning the lanes per register minus 1.
REQ-012 SHALL have port rf_addr, output, ADDR_WIDTH, meaning the registered read address to the vector register-file read port.
REQ-013 SHALL have port rf_data, input, DATA_WIDTH x LEN unpacked, meaning the combinational read data for rf_addr, with write-forwarding performed by the register file.
REQ-014 SHALL have port out_valid, output, 1, meaning a lane word is presented.
REQ-015 SHALL have port out_ready, input, 1, meaning the sink accepts the presented word.
REQ-016 SHALL have port out_data, output, DATA_WIDTH, meaning the lane word.
REQ-017 SHALL have port out_last, output, 1, meaning the final word of the command.
REQ-018 SHALL have port busy, output, 1, meaning a command is in progress.

Function
REQ-019 SHALL implement a state machine with states IDLE, FETCH and STREAM.
REQ-020 SHALL assert cmd_ready exactly when the state is IDLE and rst_n is 1, and SHALL define command acceptance as cmd_valid & cmd_ready.
REQ-021 SHALL, on acceptance, latch cmd_addr into rf_addr, load reg_cnt = cmd_nregs_m1, latch nlanes_m1, and move to FETCH.
REQ-022 SHALL ignore cmd_valid in FETCH and STREAM, with no effect on in-flight state.
REQ-023 SHALL, in FETCH, capture all LEN words of rf_data into an internal snapshot buffer, set lane_idx = 0, and move to STREAM after exactly 1 cycle.
REQ-024 SHALL, in STREAM, drive out_valid = 1 and out_data = snapshot[lane_idx].
REQ-025 SHALL assert out_last in STREAM when lane_idx == nlanes_m1 and reg_cnt == 0.
REQ-026 SHALL hold out_data and out_last stable while out_valid & !out_ready.
REQ-027 SHALL, on a handshake with lane_idx < nlanes_m1, increment lane_idx.
REQ-028 SHALL, on a handshake with lane_idx == nlanes_m1 and reg_cnt > 0, set rf_addr = rf_addr + 1 modulo 2^ADDR_WIDTH (31 wraps to 0), decrement reg_cnt, and move to FETCH.
REQ-029 SHALL, on a handshake with out_last = 1, move to IDLE.
REQ-030 SHALL, as a consequence of REQ-023 to REQ-029, have cmd_ready asserted in the cycle after the last beat.
REQ-031 SHALL deliver lanes in the order 0..nlanes_m1, then the next register.
REQ-032 SHALL unload at most LEN lanes per register (nlanes_m1 = LEN-1), and at most 2^ADDR_WIDTH registers (nregs_m1 all ones); the second case revisits no register.
REQ-033 SHALL, for a command accepted in cycle T, present the first out_valid in cycle T+2, with one FETCH bubble per register boundary.
REQ-034 SHALL stream a register's contents as of its FETCH cycle, including a same-cycle forwarded write; writes after the FETCH cycle are not reflected.
REQ-035 SHALL assert busy whenever the state is not IDLE.
REQ-036 SHALL drive out_valid = 0 and out_last = 0 outside STREAM.

Reset
REQ-037 SHALL, in any cycle with rst_n = 0, set state = IDLE, rf_addr = 0, lane_idx = 0, reg_cnt = 0, busy = 0, out_valid = 0, out_last = 0, out_data = 0, cmd_ready = 0, and accept no command.
REQ-038 SHALL, when reset asserts mid-command, abandon the command in the next cycle without emitting further beats, leaving the snapshot contents don't-care.

Verification
REQ-039 SHALL verify: reg 2 = {..., 0x3b6d8000, 0x38a36038, 0xb8cbffed}, cmd addr=2, nregs_m1=0, nlanes_m1=2, out_ready=1 -> beats 0xb8cbffed, 0x38a36038, 0x3b6d8000 in cycles T+2..T+4, out_last on the third beat, cmd_ready=1 at T+5.
REQ-040 SHALL verify: cmd addr=30, nregs_m1=2, nlanes_m1=0 -> rf_addr sequence 30, 31, 0; 3 beats with one bubble between each; out_last only on the reg 0 beat.
REQ-041 SHALL verify: out_ready toggling 1,0,0,1,... during a 9-lane unload -> out_data/out_last stable during stalls, no duplicated or lost lanes, 9 beats total.
REQ-042 SHALL verify: cmd_valid held high during STREAM with a different addr -> ignored, and accepted only once IDLE is reached.
REQ-043 SHALL verify: a register-file write to the target register in the FETCH cycle -> the new data is streamed; a write one cycle later -> the old data is streamed.
REQ-044 SHALL verify: rst_n=0 for 1 cycle at beat 3 of 16 -> out_valid=0 and busy=0 the next cycle, and a fresh command then works normally.
